// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: core data-memory port as seen by the memory-mapped UART.
interface mmio_uart_tx_if;
    logic [31:0] data_adr;
    logic [31:0] data_out;
    logic [31:0] rd_data;
    logic        mem_read;
    logic        mem_write;
    logic        sel;
    modport master (output data_adr, data_out, mem_read, mem_write, input sel, rd_data);
    modport slave  (input data_adr, data_out, mem_read, mem_write, output sel, rd_data);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADR     = 32'hFFFF_0000
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state;
    logic [BW-1:0] r_bcnt, w_bcnt;
    logic [2:0]    r_bidx, w_bidx;
    logic [7:0]    r_shift, w_shift;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic [3:0]    w_off;
    logic          r_tx, w_tx, r_en, r_ovf;
    logic          w_pop, w_push, w_go, w_end, w_empty, w_full, w_wr_tx, w_wr_ctrl;
    logic          w_unused;

    assign w_off     = bus.data_adr[3:0];
    assign bus.sel   = bus.data_adr[31:4] == BASE_ADR[31:4];
    assign w_wr_tx   = bus.sel & bus.mem_write & (w_off == 4'h0);
    assign w_wr_ctrl = bus.sel & bus.mem_write & (w_off == 4'h8);
    assign w_empty   = r_count == '0;
    assign w_full    = r_count == CW'(FIFO_DEPTH);
    assign w_go      = r_en & ~w_empty;
    assign w_end     = r_bcnt == LAST;
    // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
    assign w_push    = w_wr_tx & (~w_full | w_pop);
    assign tx        = r_tx;
    assign w_unused  = &{1'b0, bus.data_out[31:8]};

    always_comb
        bus.rd_data = !(bus.sel & bus.mem_read) ? '0 :
                      (w_off == 4'h4) ? {24'b0, 4'(r_count), r_ovf, r_state != IDLE, w_empty, w_full} :
                      (w_off == 4'h8) ? {31'b0, r_en} : '0;

    always_comb begin
        w_state = r_state;
        w_bcnt  = r_bcnt + 1'b1;
        w_bidx  = r_bidx;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_pop   = 1'b0;
        case (r_state)
            IDLE: begin
                w_bcnt = '0;
                if (w_go) begin
                    w_pop   = 1'b1;
                    w_state = START;
                    w_shift = r_mem[r_rp];
                    w_tx    = 1'b0;
                end
            end
            START: if (w_end) begin
                w_bcnt  = '0;
                w_bidx  = '0;
                w_state = DATA;
                w_tx    = r_shift[0];
            end
            DATA: if (w_end) begin
                w_bcnt  = '0;
                w_bidx  = r_bidx + 1'b1;
                w_shift = r_shift >> 1;
                w_tx    = r_shift[1];
                if (r_bidx == 3'd7) begin
                    w_state = STOP;
                    w_tx    = 1'b1;
                end
            end
            STOP: if (w_end) begin
                w_bcnt  = '0;
                w_pop   = w_go;
                w_state = w_go ? START : IDLE;
                w_tx    = ~w_go;
                w_shift = w_go ? r_mem[r_rp] : r_shift;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_bcnt  <= w_bcnt;
            r_bidx  <= w_bidx;
            r_shift <= w_shift;
            r_tx    <= w_tx;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_en    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_wr_ctrl)
                r_en <= bus.data_out[0];
            // A dropped write outranks a same-cycle clear.
            if (w_wr_tx & ~w_push)
                r_ovf <= 1'b1;
            else if (w_wr_ctrl & bus.data_out[1])
                r_ovf <= 1'b0;
        end

    always_ff @(posedge clk)
        if (w_push)
            r_mem[r_wp] <= bus.data_out[7:0];
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed checks against a frame-level model.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int CPB = 4;
    localparam int FLEN = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    int   n_chk = 0;
    int   n_err = 0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .BASE_ADR(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus), .tx(tx)
    );

    always #10 clk = ~clk;

    logic [7:0] mq[$];
    logic [7:0] m_cur;
    bit         m_act, m_en, m_ovf;
    int         m_pos;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_act = 0;
        m_pos = 0;
        m_en  = 1;
        m_ovf = 0;
    endfunction

    // Expected line level from the position inside a 10-bit frame.
    function automatic logic m_tx();
        int b;
        if (!m_act) return 1'b1;
        b = m_pos / CPB;
        return (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_cur[b-1];
    endfunction

    function automatic logic [31:0] m_status();
        return {24'b0, 4'(mq.size()), m_ovf, m_act, mq.size() == 0, mq.size() == 4};
    endfunction

    task automatic tick();
        bit         hit, wr_tx, wr_ctrl, pop, push;
        int         sz;
        logic [31:0] d;
        hit     = bus.data_adr[31:4] == BASE[31:4];
        wr_tx   = hit && bus.mem_write && bus.data_adr[3:0] == 4'h0;
        wr_ctrl = hit && bus.mem_write && bus.data_adr[3:0] == 4'h8;
        d       = bus.data_out;
        sz      = mq.size();
        pop     = (!m_act || m_pos == FLEN - 1) && m_en && sz > 0;
        push    = wr_tx && (sz < 4 || pop);
        @(posedge clk);
        #1;
        if (pop) begin
            m_cur = mq.pop_front();
            m_act = 1;
            m_pos = 0;
        end else if (m_act) begin
            if (m_pos == FLEN - 1) m_act = 0;
            else m_pos++;
        end
        if (push) mq.push_back(d[7:0]);
        if (wr_tx && !push) m_ovf = 1;
        else if (wr_ctrl && d[1]) m_ovf = 0;
        if (wr_ctrl) m_en = d[0];
        chk("tx", {31'b0, tx}, {31'b0, m_tx()});
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] data);
        bus.data_adr  = adr;
        bus.data_out  = data;
        bus.mem_write = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        bus.data_adr  = 32'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bus.data_adr = adr;
        bus.mem_read = 1'b1;
        #1;
        chk(tag, bus.rd_data, exp);
        bus.mem_read = 1'b0;
        bus.data_adr = 32'h0;
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || m_act) && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, r;
        bus.data_adr  = 32'h0;
        bus.data_out  = 32'h0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        m_reset();
        #25;
        chk("reset_tx", {31'b0, tx}, 32'h1);
        rd("reset_status", BASE + 4, 32'h02);
        rd("reset_ctrl", BASE + 8, 32'h01);
        @(negedge clk) rst = 1'b1;

        wr(BASE, 32'h55);
        rd("status_after_push", BASE + 4, m_status());
        repeat (FLEN + 1) tick();
        rd("status_after_55", BASE + 4, 32'h02);

        for (int i = 1; i <= 6; i++) wr(BASE, i);
        rd("status_overflow", BASE + 4, m_status());
        chk("overflow_set", {31'b0, m_ovf}, 32'h1);
        wr(BASE + 8, 32'h3);
        rd("status_ovf_clr", BASE + 4, m_status());
        rd("ctrl_after_clr", BASE + 8, 32'h01);
        drain();
        rd("status_burst_done", BASE + 4, 32'h02);

        wr(BASE + 8, 32'h0);
        wr(BASE, 32'hA5);
        repeat (12) tick();
        rd("status_disabled", BASE + 4, 32'h10);
        wr(BASE + 8, 32'h1);
        drain();

        wr(BASE, 32'h3C);
        wr(BASE, 32'hC3);
        n = 0;
        while (!(m_act && m_pos / CPB == 4) && n < 200) begin
            tick();
            n++;
        end
        #2 rst = 1'b0;
        #1 chk("tx_async_reset", {31'b0, tx}, 32'h1);
        m_reset();
        @(negedge clk) rst = 1'b1;
        rd("status_after_rst", BASE + 4, 32'h02);
        repeat (50) tick();

        bus.data_adr = 32'h0000_0010;
        #1 chk("sel_miss", {31'b0, bus.sel}, 32'h0);
        bus.data_adr = BASE + 32'hC;
        #1 chk("sel_hit", {31'b0, bus.sel}, 32'h1);
        wr(32'h0000_0010, 32'h77);
        wr(BASE + 32'hC, 32'h76);
        rd("status_bad_wr", BASE + 4, 32'h02);
        rd("ctrl_bad_wr", BASE + 8, 32'h01);
        rd("read_txdata", BASE, 32'h0);
        rd("read_reserved", BASE + 32'hC, 32'h0);
        rd("read_miss", 32'h0000_0004, 32'h0);

        repeat (500) begin
            r = $urandom_range(0, 99);
            if (r < 30) wr(BASE, $urandom);
            else if (r < 34) wr(BASE + 8, ($urandom_range(0, 3) == 0) ? {30'b0, 1'($urandom_range(0, 1)), 1'b0} : {30'b0, 1'($urandom_range(0, 1)), 1'b1});
            else if (r < 36) wr(BASE + 4, $urandom);
            else if (r < 50) begin
                rd("rand_status", BASE + 4, m_status());
                rd("rand_ctrl", BASE + 8, {31'b0, m_en});
                tick();
            end else tick();
        end
        wr(BASE + 8, 32'h3);
        drain();
        rd("final_status", BASE + 4, 32'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
